// File: rtl/gearbox_tx_flow.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_tx_flow
// Brief    : 64b/66b transmit gearbox with valid/ready flow control. Packs
//            {data, sync header} blocks, fed as DATA_W chunks, into a
//            continuous DATA_W-bit PMA word stream; drains its residue once
//            every 33 output words.
// Options  : define GEARBOX_TX_HEAD_CHECK_EN to enable the illegal sync
//            header flag (head_err_o); otherwise it is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module gearbox_tx_flow #(
    parameter int DATA_W       = 64,
    parameter int BLOCK_DATA_W = 64,
    parameter int HEAD_W       = 2,
    parameter int SEQ_W        = $clog2(33)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [SEQ_W-1:0]  seq_o,
    output logic              head_err_o
);

    localparam int c_chunks = BLOCK_DATA_W / DATA_W;
    localparam int c_cnt_w  = (c_chunks > 1) ? $clog2(c_chunks) : 1;
    localparam int c_fill_w = $clog2(DATA_W + 1);
    localparam int c_comb_w = 2 * DATA_W;
    localparam logic [SEQ_W-1:0]   c_seq_drain = SEQ_W'(32);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(c_chunks - 1);

    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic [SEQ_W-1:0]    r_seq;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_buf;
    logic [c_fill_w-1:0] r_fill;

    logic                w_drain;
    logic                w_accept;
    logic                w_first;
    logic [c_fill_w-1:0] w_fill_add;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic [c_comb_w-1:0] w_new;
    logic [c_comb_w-1:0] w_comb;

    assign w_drain    = (r_seq == c_seq_drain);
    assign w_accept   = valid_i & ~w_drain;
    assign w_first    = (r_cnt == '0);
    assign w_fill_add = w_first ? c_fill_w'(HEAD_W) : '0;
    assign w_cnt_next = (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);

    // Bits of r_buf at and above r_fill are always zero, so the new chunk
    // can simply be OR-ed in above the residue.
    always_comb begin
        w_new = '0;
        if (w_first) begin
            w_new = {{(DATA_W - HEAD_W){1'b0}}, data_i, head_i};
        end else begin
            w_new = {{DATA_W{1'b0}}, data_i};
        end
        w_comb = (w_new << r_fill) | {{DATA_W{1'b0}}, r_buf};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_seq   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_fill  <= '0;
        end else if (w_drain) begin
            // Residue is exactly one full word here; chunk index is untouched.
            r_data  <= r_buf;
            r_buf   <= '0;
            r_fill  <= '0;
            r_seq   <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_data  <= w_comb[DATA_W-1:0];
            r_buf   <= w_comb[c_comb_w-1:DATA_W];
            r_fill  <= r_fill + w_fill_add;
            r_cnt   <= w_cnt_next;
            r_seq   <= r_seq + SEQ_W'(1);
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

`ifdef GEARBOX_TX_HEAD_CHECK_EN
    logic r_head_err;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_head_err <= 1'b0;
        end else begin
            r_head_err <= w_accept & w_first & ((head_i == '0) | (head_i == '1));
        end
    end

    assign head_err_o = r_head_err;
`else
    assign head_err_o = 1'b0;
`endif

    assign ready_o = ~w_drain;
    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign seq_o   = r_seq;

endmodule
`default_nettype wire

// File: doc/gearbox_tx_flow.md
# gearbox_tx_flow

Parametrised, self-sequencing 64b/66b transmit gearbox with valid/ready flow control. It packs `{data, sync header}` blocks supplied in `DATA_W`-bit chunks into a continuous `DATA_W`-bit PMA word stream. It keeps its own sequence counter and back-pressures the PCS once every 33 cycles to drain its residue. It also tolerates source gaps. It sits between the PCS scrambler output and the PMA serializer.

## Interface
- `DATA_W`, 64, PCS/PMA word width; legal values are 16, 32, 64.
- `BLOCK_DATA_W`, 64, payload bits per block.
- `HEAD_W`, 2, sync header width.
- `SEQ_W`, `$clog2(33)`=6, sequence counter width.
- `clk`  in  1  clock.
- `nreset`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  input chunk valid.
- `head_i`  in  HEAD_W  sync header; sampled only on the first chunk of a block.
- `data_i`  in  DATA_W  scrambled payload chunk; chunk 0 holds payload bits [DATA_W-1:0].
- `ready_o`  out  1  gearbox accepts a chunk this cycle.
- `valid_o`  out  1  `data_o` holds a new PMA word.
- `data_o`  out  DATA_W  PMA word, LSB transmitted first.
- `seq_o`  out  SEQ_W  current sequence position, 0..32.
- `head_err_o`  out  1  illegal sync header flag (see Configuration).

## Operation
- Internal state:
  - `seq_q` (0..32).
  - Chunk index `cnt_q` (0..BLOCK_DATA_W/DATA_W-1).
  - Residue buffer `buf_q` (DATA_W bits) and residue fill `fill_q` (0..DATA_W, multiple of HEAD_W).
- `ready_o = (seq_q != 32)`. This is combinational from state only, with no path from `valid_i`.
- Accept cycle (`valid_i & ready_o`):
  - `first = (cnt_q == 0)`.
  - Combined vector = `{data_i, first ? head_i : none, buf_q[fill_q-1:0]}`, LSB first.
  - `data_o` <= combined[DATA_W-1:0]; the next `buf_q` holds the remaining bits.
  - `fill_q` += `first ? HEAD_W : 0`.
  - `cnt_q` increments and wraps.
  - `seq_q` increments.
  - `valid_o` <= 1.
- Drain cycle (`seq_q == 32`, so `fill_q == DATA_W`):
  - `data_o` <= `buf_q`; `fill_q` <= 0; `seq_q` <= 0; `valid_o` <= 1.
  - `valid_i` is ignored and the source must hold its chunk.
  - `cnt_q` is unchanged.
- Idle cycle (`valid_i == 0` and `ready_o == 1`): no state change, `valid_o` <= 0, `data_o` holds its previous value.
- The period is always 33 output words per 32 accepted chunks, for every legal `DATA_W`:
  - DATA_W=64: drain after 32 blocks.
  - DATA_W=32: drain after 16 blocks.
  - DATA_W=16: drain after 8 blocks.
- `seq_o = seq_q`.

## Timing
- Latency: the chunk accepted at edge N appears on `data_o`/`valid_o` after edge N, i.e. 1 cycle, registered.
- Reset (async assert, sync release): `data_o`=0, `valid_o`=0, `seq_o`=0, `head_err_o`=0, `cnt_q`=0, `fill_q`=0, `buf_q`=0. `ready_o`=1 during and after reset.
- Reset mid-block or mid-period discards the residue. The first chunk accepted after release is treated as chunk 0 of a new block.
- No combinational path from inputs to any output.
- Wrap-around: `seq_q` goes 32 -> 0 on the drain cycle only. `cnt_q` wraps independently of `seq_q`.
- Simultaneous `valid_i=1` and drain: drain wins and the chunk is not consumed.

## Configuration
- `GEARBOX_TX_HEAD_CHECK_EN`:
  - Defined: on each accept with `first=1`, `head_err_o` <= (`head_i` == 2'b00 or 2'b11). The flag is a one-cycle pulse aligned with that word's `valid_o`.
  - Undefined: `head_err_o` is tied to 0 and no check logic is synthesised.

## Test plan
- Reset: `nreset`=0 at seq 17 mid-stream -> all outputs 0 and `ready_o`=1 next cycle. After release, the first word is `{D[61:0],head}` of the new block (DATA_W=64).
- DATA_W=64, `head_i`=2'b01, data_k=k, continuous `valid_i`:
  - Word 0 = `{62'd0, 2'b01}`.
  - Word 1 = `{60'd1, 2'b01, 2'b00}`.
  - `ready_o`=0 exactly at seq 32.
  - Word 32 = 64'd31.
  - Then seq 0 again.
- Gap: `valid_i`=0 for 3 cycles at seq 5 -> `valid_o`=0 for 3 cycles, `seq_o` stays 5, and the concatenated valid words are identical to the gap-free run.
- DATA_W=16, `head_i`=2'b10 on chunk 0 and 2'b11 on chunks 1..3 -> only 2'b10 appears in the stream. `ready_o`=0 once after every 32 accepts (8 blocks), and the drain word equals the upper 16 bits of block 7.
- Drain collision: `valid_i`=1 with chunk X during seq 32 -> X is not consumed, and X appears as the low bits of the word following the drain.
- Head check: `head_i`=2'b11 on a block start -> `head_err_o`=1 for one cycle with `GEARBOX_TX_HEAD_CHECK_EN` defined, and 0 without it.
